// File: rtl/carfield_eoc_monitor.sv
// Multi-channel end-of-computation monitor.
// After a start delay, polls one return register per enabled channel in
// round-robin order through a single-outstanding read port. It collects the
// per-channel EOC flags and exit codes, then reports an aggregate
// done/pass/timeout result.
module carfield_eoc_monitor #(
  parameter int unsigned NumChannels  = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned DelayWidth   = 20,
  parameter int unsigned TimeoutWidth = 32,
  localparam int unsigned ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int unsigned CodeW = DataWidth - 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NumChannels-1:0]       chan_mask_i,
  input  logic [DelayWidth-1:0]        delay_i,
  input  logic [TimeoutWidth-1:0]      timeout_i,
  output logic                         rd_req_o,
  output logic [ChanW-1:0]             rd_chan_o,
  input  logic                         rd_gnt_i,
  input  logic                         rd_valid_i,
  input  logic [DataWidth-1:0]         rd_data_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic                         timeout_o,
  output logic [NumChannels-1:0]       eoc_o,
  output logic [NumChannels*CodeW-1:0] exit_code_o,
  output logic [ChanW-1:0]             fail_chan_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_POLL  = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [NumChannels-1:0]  mask_q, mask_d;
  logic [NumChannels-1:0]  eoc_q, eoc_d;
  logic [DelayWidth-1:0]   dcnt_q, dcnt_d;
  logic [TimeoutWidth-1:0] tlim_q, tlim_d;
  logic [TimeoutWidth-1:0] tcnt_q, tcnt_d;
  logic [ChanW-1:0]        last_q, last_d;
  logic [CodeW-1:0]        code_q [NumChannels];
  logic [CodeW-1:0]        code_d [NumChannels];
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    tmo_q, tmo_d;
  logic [ChanW-1:0]        fail_q, fail_d;

  logic                    sel_vld;
  logic [ChanW-1:0]        sel_chan;
  logic [ChanW-1:0]        sel_idx;
  logic                    tmo_hit;
  logic                    req;
  logic                    finish;
  logic                    finish_tmo;
  logic                    fail_found;
  logic [ChanW-1:0]        fail_chan;

  // Round-robin pick: first enabled, not-yet-finished channel after last_q.
  // last_q only moves on a grant and eoc_q only changes in WAIT, so the
  // selection stays stable for the whole time a request is pending.
  always_comb begin
    sel_vld  = 1'b0;
    sel_chan = '0;
    sel_idx  = '0;
    for (int unsigned k = 1; k <= NumChannels; k++) begin
      sel_idx = ChanW'((32'(last_q) + k) % NumChannels);
      if (!sel_vld && mask_q[sel_idx] && !eoc_q[sel_idx]) begin
        sel_vld  = 1'b1;
        sel_chan = sel_idx;
      end
    end
  end

  // Timeout compare; a zero limit disables it.
  always_comb begin
    tmo_hit = (tlim_q != '0) && (tcnt_q == tlim_q) &&
              ((state_q == S_POLL) || (state_q == S_WAIT));
  end

  // Next-state, capture and result logic.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    eoc_d      = eoc_q;
    dcnt_d     = dcnt_q;
    tlim_d     = tlim_q;
    tcnt_d     = tcnt_q;
    last_d     = last_q;
    code_d     = code_q;
    done_d     = done_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    fail_d     = fail_q;
    req        = 1'b0;
    finish     = 1'b0;
    finish_tmo = 1'b0;
    fail_found = 1'b0;
    fail_chan  = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_DELAY;
          mask_d  = chan_mask_i;
          dcnt_d  = delay_i;
          tlim_d  = timeout_i;
          tcnt_d  = '0;
          // Seed with the top index so that the first poll lands on index 0.
          last_d  = ChanW'(NumChannels - 1);
          eoc_d   = '0;
          for (int unsigned i = 0; i < NumChannels; i++) begin
            code_d[i] = '0;
          end
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          fail_d  = '0;
        end
      end

      S_DELAY: begin
        if (dcnt_q == '0) begin
          if (mask_q == '0) begin
            finish = 1'b1;
          end else begin
            state_d = S_POLL;
            tcnt_d  = '0;
          end
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end

      S_POLL: begin
        tcnt_d = tcnt_q + 1'b1;
        if (tmo_hit) begin
          // An ungranted request is simply withdrawn.
          finish     = 1'b1;
          finish_tmo = 1'b1;
        end else if (!sel_vld) begin
          finish = 1'b1;
        end else begin
          req = 1'b1;
          if (rd_gnt_i) begin
            last_d  = sel_chan;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (rd_valid_i) begin
          if (rd_data_i[0]) begin
            eoc_d[last_q]  = 1'b1;
            code_d[last_q] = rd_data_i[DataWidth-1:1];
          end
          // Completion takes priority over a timeout in the same cycle.
          if ((eoc_d & mask_q) == mask_q) begin
            finish = 1'b1;
          end else if (tmo_hit) begin
            finish     = 1'b1;
            finish_tmo = 1'b1;
          end else begin
            state_d = S_POLL;
          end
        end else if (tmo_hit) begin
          // A read is still in flight; its response must be absorbed first.
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (rd_valid_i) begin
          finish     = 1'b1;
          finish_tmo = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    for (int unsigned i = 0; i < NumChannels; i++) begin
      if (!fail_found && mask_q[i] && (code_d[i] != '0)) begin
        fail_found = 1'b1;
        fail_chan  = ChanW'(i);
      end
    end

    if (finish) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      tmo_d   = finish_tmo;
      pass_d  = !finish_tmo && !fail_found;
      fail_d  = fail_chan;
    end
  end

  // State and capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      eoc_q   <= '0;
      dcnt_q  <= '0;
      tlim_q  <= '0;
      tcnt_q  <= '0;
      last_q  <= '0;
      for (int unsigned i = 0; i < NumChannels; i++) begin
        code_q[i] <= '0;
      end
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      eoc_q   <= eoc_d;
      dcnt_q  <= dcnt_d;
      tlim_q  <= tlim_d;
      tcnt_q  <= tcnt_d;
      last_q  <= last_d;
      for (int unsigned i = 0; i < NumChannels; i++) begin
        code_q[i] <= code_d[i];
      end
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      fail_q  <= fail_d;
    end
  end

  // Output mapping.
  always_comb begin
    rd_req_o    = req;
    rd_chan_o   = req ? sel_chan : '0;
    busy_o      = (state_q == S_DELAY) || (state_q == S_POLL) ||
                  (state_q == S_WAIT)  || (state_q == S_DRAIN);
    done_o      = done_q;
    pass_o      = pass_q;
    timeout_o   = tmo_q;
    eoc_o       = eoc_q;
    fail_chan_o = fail_q;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      exit_code_o[i*CodeW +: CodeW] = code_q[i];
    end
  end

endmodule

// File: tb/tb_carfield_eoc_monitor.sv
// Directed bench for carfield_eoc_monitor with a small read-port responder
// and a scoreboard of expected grant channels.
module tb_carfield_eoc_monitor;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int CODEW = DW - 1;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [NC-1:0]     chan_mask_i;
  logic [19:0]       delay_i;
  logic [31:0]       timeout_i;
  logic              rd_req_o;
  logic [1:0]        rd_chan_o;
  logic              rd_gnt_i;
  logic              rd_valid_i;
  logic [DW-1:0]     rd_data_i;
  logic              busy_o;
  logic              done_o;
  logic              pass_o;
  logic              timeout_o;
  logic [NC-1:0]     eoc_o;
  logic [NC*CODEW-1:0] exit_code_o;
  logic [1:0]        fail_chan_o;

  always #5 clk = ~clk;

  carfield_eoc_monitor #(
    .NumChannels(NC), .DataWidth(DW), .DelayWidth(20), .TimeoutWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .chan_mask_i(chan_mask_i),
    .delay_i(delay_i), .timeout_i(timeout_i), .rd_req_o(rd_req_o),
    .rd_chan_o(rd_chan_o), .rd_gnt_i(rd_gnt_i), .rd_valid_i(rd_valid_i),
    .rd_data_i(rd_data_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .eoc_o(eoc_o), .exit_code_o(exit_code_o),
    .fail_chan_o(fail_chan_o)
  );

  int checks = 0;
  int errors = 0;

  // Responder state: per-channel response for the first and later polls.
  logic [DW-1:0] resp_data [NC][2];
  int            poll_n [NC];
  int            resp_lat;
  int            gnt_stop;
  bit            pend;
  int            pend_cnt;
  logic [1:0]    pend_chan;
  int            grants, req_cycles, last_valid_cyc, done_cyc, first_req_cyc;
  logic [1:0]    exp_chan_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input logic [1:0] obs);
    logic [1:0] exp;
    checks++;
    assert (exp_chan_q.size() != 0) else begin
      errors++;
      $error("FAIL grant_unexpected: observed chan %0d expected no grant", obs);
    end
    if (exp_chan_q.size() != 0) begin
      exp = exp_chan_q.pop_front();
      chk("grant_chan", 64'(obs), 64'(exp));
    end
  endtask

  task automatic clear_bench();
    pend = 1'b0; pend_cnt = 0; pend_chan = '0;
    grants = 0; req_cycles = 0; last_valid_cyc = -1; done_cyc = -1; first_req_cyc = -1;
    resp_lat = 1; gnt_stop = 1000000;
    exp_chan_q.delete();
    for (int i = 0; i < NC; i++) begin
      poll_n[i] = 0; resp_data[i][0] = '0; resp_data[i][1] = '0;
    end
  endtask

  task automatic do_start(input logic [NC-1:0] m, input logic [19:0] d, input logic [31:0] t);
    @(negedge clk);
    start_i = 1'b1; chan_mask_i = m; delay_i = d; timeout_i = t;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Drive the read port one cycle at a time until done_o or budget expiry.
  task automatic run(input int max_cyc, input bit expect_done);
    bit seen;
    int idx;
    seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clk);
      start_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = '0; rd_gnt_i = 1'b0;
      if (done_o) begin
        seen = 1'b1; done_cyc = c;
      end else begin
        if (pend) begin
          if (pend_cnt <= 1) begin
            idx = (poll_n[pend_chan] < 2) ? poll_n[pend_chan] : 1;
            rd_valid_i = 1'b1;
            rd_data_i  = resp_data[pend_chan][idx];
            poll_n[pend_chan]++;
            pend = 1'b0;
            last_valid_cyc = c;
          end else begin
            pend_cnt--;
          end
        end
        if (rd_req_o) begin
          if (first_req_cyc < 0) first_req_cyc = c;
          req_cycles++;
          if (c < gnt_stop) begin
            rd_gnt_i = 1'b1;
            grants++;
            chk_grant(rd_chan_o);
            pend = 1'b1; pend_cnt = resp_lat; pend_chan = rd_chan_o;
          end
        end
      end
    end
    if (expect_done) chk("done_within_budget", 64'(seen), 64'd1);
  endtask

  // All four channels finish on their second poll; ch3 code is last_data.
  task automatic t_all_four(input logic [DW-1:0] last_data, input bit exp_pass);
    clear_bench();
    for (int i = 0; i < NC; i++) resp_data[i][1] = 32'h1;
    resp_data[3][1] = last_data;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NC; i++) exp_chan_q.push_back(2'(i));
    do_start(4'b1111, 20'd3, 32'd0);
    run(200, 1'b1);
    chk("all4_first_req_after_delay", 64'(first_req_cyc), 64'd3);
    chk("all4_grants", 64'(grants), 64'd8);
    chk("all4_done_latency", 64'(done_cyc), 64'(last_valid_cyc + 1));
    chk("all4_pass", 64'(pass_o), 64'(exp_pass));
    chk("all4_timeout", 64'(timeout_o), 64'd0);
    chk("all4_eoc", 64'(eoc_o), 64'hF);
    chk("all4_fail_chan", 64'(fail_chan_o), exp_pass ? 64'd0 : 64'd3);
    chk("all4_code3", 64'(exit_code_o[3*CODEW +: CODEW]), 64'(last_data[DW-1:1]));
    chk("all4_busy", 64'(busy_o), 64'd0);
    chk("all4_sb_empty", 64'(exp_chan_q.size()), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; chan_mask_i = '0; delay_i = '0; timeout_i = '0;
    rd_gnt_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = '0;
    clear_bench();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_req", 64'(rd_req_o), 64'd0);
    chk("rst_eoc", 64'(eoc_o), 64'd0);
    chk("rst_codes", 64'(exit_code_o != '0), 64'd0);

    // Full round-robin, every channel clean.
    t_all_four(32'h1, 1'b1);

    // Sparse mask, channel 2 reports code 3.
    clear_bench();
    resp_data[0][0] = 32'h1; resp_data[0][1] = 32'h1;
    resp_data[2][0] = 32'h7; resp_data[2][1] = 32'h7;
    exp_chan_q.push_back(2'd0); exp_chan_q.push_back(2'd2);
    do_start(4'b0101, 20'd0, 32'd0);
    run(200, 1'b1);
    chk("sparse_grants", 64'(grants), 64'd2);
    chk("sparse_pass", 64'(pass_o), 64'd0);
    chk("sparse_fail_chan", 64'(fail_chan_o), 64'd2);
    chk("sparse_code2", 64'(exit_code_o[2*CODEW +: CODEW]), 64'd3);
    chk("sparse_code0", 64'(exit_code_o[0 +: CODEW]), 64'd0);
    chk("sparse_eoc", 64'(eoc_o), 64'h5);

    // Timeout in POLL: grants stop at cycle 48, limit 50.
    clear_bench();
    gnt_stop = 48;
    for (int i = 0; i < 24; i++) exp_chan_q.push_back(2'd0);
    do_start(4'b0001, 20'd0, 32'd50);
    run(200, 1'b1);
    chk("tmo_poll_done_cycle", 64'(done_cyc), 64'd51);
    chk("tmo_poll_grants", 64'(grants), 64'd24);
    chk("tmo_poll_req_cycles", 64'(req_cycles), 64'd26);
    chk("tmo_poll_timeout", 64'(timeout_o), 64'd1);
    chk("tmo_poll_pass", 64'(pass_o), 64'd0);
    chk("tmo_poll_eoc", 64'(eoc_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_poll_no_req", 64'(rd_req_o), 64'd0);
      @(negedge clk);
    end

    // Timeout in WAIT; the late response carries EOC but must be discarded.
    clear_bench();
    resp_lat = 20;
    resp_data[0][0] = 32'h1;
    exp_chan_q.push_back(2'd0);
    do_start(4'b0001, 20'd0, 32'd10);
    run(200, 1'b1);
    chk("drain_valid_cycle", 64'(last_valid_cyc), 64'd20);
    chk("drain_done_cycle", 64'(done_cyc), 64'd21);
    chk("drain_timeout", 64'(timeout_o), 64'd1);
    chk("drain_pass", 64'(pass_o), 64'd0);
    chk("drain_eoc", 64'(eoc_o), 64'd0);

    // Completion and timeout on the same cycle resolve as completion.
    clear_bench();
    resp_lat = 2;
    resp_data[0][0] = 32'h1;
    exp_chan_q.push_back(2'd0);
    do_start(4'b0001, 20'd0, 32'd2);
    run(50, 1'b1);
    chk("collide_done_cycle", 64'(done_cyc), 64'd3);
    chk("collide_timeout", 64'(timeout_o), 64'd0);
    chk("collide_pass", 64'(pass_o), 64'd1);
    chk("collide_eoc", 64'(eoc_o), 64'd1);

    // Empty mask, zero delay.
    clear_bench();
    do_start(4'b0000, 20'd0, 32'd0);
    run(20, 1'b1);
    chk("empty_done_cycle", 64'(done_cyc), 64'd0);
    chk("empty_pass", 64'(pass_o), 64'd1);
    chk("empty_req", 64'(req_cycles), 64'd0);

    // Empty mask with delay; a start pulse during DELAY is ignored.
    clear_bench();
    do_start(4'b0000, 20'd5, 32'd0);
    start_i = 1'b1; chan_mask_i = 4'b1111; delay_i = 20'd0;
    run(40, 1'b1);
    chk("ign_done_cycle", 64'(done_cyc), 64'd5);
    chk("ign_req", 64'(req_cycles), 64'd0);
    chk("ign_pass", 64'(pass_o), 64'd1);

    // Reset while waiting for read data.
    clear_bench();
    resp_lat = 10;
    exp_chan_q.push_back(2'd0);
    do_start(4'b1111, 20'd0, 32'd0);
    run(3, 1'b0);
    @(negedge clk);
    rst_i = 1'b1; pend = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_req", 64'(rd_req_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    rd_valid_i = 1'b1; rd_data_i = 32'h1;
    @(negedge clk);
    rd_valid_i = 1'b0; rd_data_i = '0;
    chk("stray_eoc", 64'(eoc_o), 64'd0);
    chk("stray_busy", 64'(busy_o), 64'd0);

    // Fresh run after reset; ch3 returns an all-ones exit code.
    t_all_four(32'hFFFF_FFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
